// File: rtl/l1_loss_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l1_pkg (file l1_loss_sequencer_pkg.sv)
// Description : Shared types and width helpers for the L1 loss sequencer.
//               Optional feature macro used elsewhere: L1_ACC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package l1_pkg;

    localparam int IL_DEF = 4;
    localparam int FL_DEF = 16;

    // Q(IL.FL) sample at the default format
    typedef logic signed [IL_DEF+FL_DEF-1:0] fix_t;

    // Sequencer states; the FSM register uses these values as plain constants
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Batch accumulator width: sample width plus growth for MAX_BATCH terms
    function automatic int acc_w(input int il, input int fl, input int max_batch);
        return il + fl + $clog2(max_batch);
    endfunction

    // Pairs per chunk: the largest value the width-bit num port can carry
    function automatic int chunk_len(input int lanes);
        return (1 << $clog2(lanes)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_loss_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : l1_loss_sequencer_if
// Description : Sample stream, loss result and control bundle of the L1 loss
//               sequencer. sat_flag exists only when L1_ACC_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface l1_loss_sequencer_if
    import l1_pkg::*;
#(
    parameter int IL        = 4,
    parameter int FL        = 16,
    parameter int MAX_BATCH = 256
);
    localparam int LW   = $clog2(MAX_BATCH + 1);
    localparam int ACCW = acc_w(IL, FL, MAX_BATCH);

    logic                   start;
    logic [LW-1:0]          batch_len;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IL+FL-1:0] in_yhat;
    logic signed [IL+FL-1:0] in_y;
    logic signed [ACCW-1:0] loss;
    logic                   loss_valid;
    logic                   loss_ready;
    logic                   busy;
`ifdef L1_ACC_SAT_EN
    logic                   sat_flag;
`endif

    modport master (
        output start, batch_len, in_valid, in_yhat, in_y, loss_ready,
`ifdef L1_ACC_SAT_EN
        input  sat_flag,
`endif
        input  in_ready, loss, loss_valid, busy
    );

    modport slave (
        input  start, batch_len, in_valid, in_yhat, in_y, loss_ready,
`ifdef L1_ACC_SAT_EN
        output sat_flag,
`endif
        output in_ready, loss, loss_valid, busy
    );

endinterface
`default_nettype wire

// File: rtl/l1_loss_sequencer_l1.sv
`default_nettype none
// ============================================================================
// Module      : l1
// Description : L1 datapath. Sums |yHat[i]-y[i]| over the first num lanes.
//               Output is zero while held in reset or not enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module l1 #(
    parameter int IL   = 4,
    parameter int FL   = 16,
    parameter int size = 16
) (
    input  logic                           reset,
    input  logic                           en,
    input  logic signed [IL+FL-1:0]        yHat [size],
    input  logic signed [IL+FL-1:0]        y    [size],
    input  logic [$clog2(size)-1:0]        num,
    output logic signed [IL+FL+$clog2(size):0] sum
);
    localparam int WIDTH = $clog2(size);
    localparam int SUMW  = IL + FL + WIDTH + 1;

    // Combinational absolute-difference reduction over active lanes
    always_comb begin
        logic signed [IL+FL:0] diff;
        logic signed [IL+FL:0] mag;
        sum  = '0;
        diff = '0;
        mag  = '0;
        if (!reset && en) begin
            for (int i = 0; i < size; i++) begin
                if (i < int'(num)) begin
                    // one extra bit so max-minus-min cannot overflow
                    diff = {yHat[i][IL+FL-1], yHat[i]} - {y[i][IL+FL-1], y[i]};
                    mag  = diff[IL+FL] ? -diff : diff;
                    sum  = sum + SUMW'(mag);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/l1_loss_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : l1_loss_sequencer
// Description : Feeds a batch of (yHat, y) pairs through one L1 datapath in
//               chunks of size-1 lanes and accumulates the batch L1 loss.
//               Macro L1_ACC_SAT_EN: saturating accumulator plus sat_flag.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_loss_sequencer
    import l1_pkg::*;
#(
    parameter int IL        = 4,
    parameter int FL        = 16,
    parameter int size      = 16,
    parameter int MAX_BATCH = 256
) (
    input  logic                clk,
    input  logic                reset,
    l1_loss_sequencer_if.slave  bus
);
    localparam int WIDTH = $clog2(size);
    localparam int LW    = $clog2(MAX_BATCH + 1);
    localparam int ACCW  = acc_w(IL, FL, MAX_BATCH);
    localparam int CHUNK = chunk_len(size);
    localparam int SUMW  = IL + FL + WIDTH + 1;
    // Adder width large enough that acc+sum never overflows before the clamp
    localparam int WW    = ((ACCW > SUMW) ? ACCW : SUMW) + 1;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_FILL    = FILL;
    localparam logic [1:0] ST_COMPUTE = COMPUTE;
    localparam logic [1:0] ST_DONE    = DONE;

    localparam logic [WIDTH-1:0] LAST_LANE = WIDTH'(CHUNK - 1);

    logic [1:0]              r_state;
    logic [WIDTH-1:0]        r_lane;
    logic [LW-1:0]           r_remaining;
    logic signed [ACCW-1:0]  r_acc;
    logic signed [IL+FL-1:0] r_yhat_buf [size];
    logic signed [IL+FL-1:0] r_y_buf    [size];

    logic                    w_l1_en;
    logic                    w_l1_reset;
    logic signed [SUMW-1:0]  w_sum;
    logic signed [WW-1:0]    w_total;
    logic signed [ACCW-1:0]  w_next_acc;
    logic                    w_take;

    assign w_l1_en    = (r_state == ST_COMPUTE);
    assign w_l1_reset = ~w_l1_en;
    assign w_take     = (r_state == ST_FILL) && bus.in_valid;

    l1 #(
        .IL   (IL),
        .FL   (FL),
        .size (size)
    ) L1_0 (
        .reset (w_l1_reset),
        .en    (w_l1_en),
        .yHat  (r_yhat_buf),
        .y     (r_y_buf),
        .num   (r_lane),
        .sum   (w_sum)
    );

    assign w_total = WW'(r_acc) + WW'(w_sum);

`ifdef L1_ACC_SAT_EN
    localparam logic signed [WW-1:0] ACC_MAX = {{(WW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
    localparam logic signed [WW-1:0] ACC_MIN = {{(WW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};

    logic w_clamp;
    logic r_sat_flag;

    // Clamp the chunk sum into the signed accumulator range
    always_comb begin
        w_clamp    = 1'b0;
        w_next_acc = w_total[ACCW-1:0];
        if (w_total > ACC_MAX) begin
            w_clamp    = 1'b1;
            w_next_acc = ACC_MAX[ACCW-1:0];
        end else if (w_total < ACC_MIN) begin
            w_clamp    = 1'b1;
            w_next_acc = ACC_MIN[ACCW-1:0];
        end
    end

    // Sticky saturation status, cleared when a new batch starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat_flag <= 1'b0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_sat_flag <= 1'b0;
        end else if (r_state == ST_COMPUTE && w_clamp) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign bus.sat_flag = r_sat_flag;
`else
    assign w_next_acc = w_total[ACCW-1:0];
`endif

    // Batch FSM with lane buffer and accumulator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lane      <= '0;
            r_remaining <= '0;
            r_acc       <= '0;
            for (int i = 0; i < size; i++) begin
                r_yhat_buf[i] <= '0;
                r_y_buf[i]    <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_remaining <= bus.batch_len;
                        r_acc       <= '0;
                        r_lane      <= '0;
                        r_state     <= (bus.batch_len == '0) ? ST_DONE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_take) begin
                        r_yhat_buf[r_lane] <= bus.in_yhat;
                        r_y_buf[r_lane]    <= bus.in_y;
                        r_lane             <= r_lane + WIDTH'(1);
                        r_remaining        <= r_remaining - LW'(1);
                        if (r_lane == LAST_LANE || r_remaining == LW'(1)) begin
                            r_state <= ST_COMPUTE;
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_acc  <= w_next_acc;
                    r_lane <= '0;
                    for (int i = 0; i < size; i++) begin
                        r_yhat_buf[i] <= '0;
                        r_y_buf[i]    <= '0;
                    end
                    r_state <= (r_remaining == '0) ? ST_DONE : ST_FILL;
                end
                default: begin
                    if (bus.loss_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready   = (r_state == ST_FILL);
    assign bus.loss_valid = (r_state == ST_DONE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.loss       = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_l1_loss_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1_loss_sequencer
// Description : Self-checking bench for l1_loss_sequencer. Expected losses
//               come from a sum-of-absolute-differences model. Follows the
//               L1_ACC_SAT_EN macro for saturate/wrap expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_loss_sequencer;
    import l1_pkg::*;

    localparam int ACCW_A = 28;   // 4+16+log2(256)
    localparam int ACCW_B = 21;   // 4+16+log2(2)

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    l1_loss_sequencer_if #(.IL(4), .FL(16), .MAX_BATCH(256)) bus_a ();
    l1_loss_sequencer_if #(.IL(4), .FL(16), .MAX_BATCH(2))   bus_b ();

    l1_loss_sequencer #(.IL(4), .FL(16), .size(16), .MAX_BATCH(256)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    l1_loss_sequencer #(.IL(4), .FL(16), .size(16), .MAX_BATCH(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ya [256];
    int ra [256];

    // Observed-cycle counters (COMPUTE = busy, not accepting, no result yet)
    int n_compute_a = 0;
    int n_inready_a = 0;
    always @(posedge clk) begin
        if (bus_a.busy && !bus_a.in_ready && !bus_a.loss_valid) n_compute_a <= n_compute_a + 1;
        if (bus_a.in_ready) n_inready_a <= n_inready_a + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rand_fix();
        int v;
        v = int'($urandom_range(0, (1 << 20) - 1));
        if (v >= (1 << 19)) v -= (1 << 20);
        return v;
    endfunction

    // Batch loss = sum of |yHat-y|; increments are never negative, so a
    // saturating accumulator ends at min(total, max), a wrapping one at total mod 2^accw
    function automatic longint model(input int len, input int accw);
        longint tot;
        longint d;
        longint m;
        tot = 0;
        for (int i = 0; i < len; i++) begin
            d = longint'(ya[i]) - longint'(ra[i]);
            tot += (d < 0) ? -d : d;
        end
`ifdef L1_ACC_SAT_EN
        m = (longint'(1) << (accw - 1)) - 1;
        return (tot > m) ? m : tot;
`else
        m = tot % (longint'(1) << accw);
        if (m >= (longint'(1) << (accw - 1))) m -= (longint'(1) << accw);
        return m;
`endif
    endfunction

    task automatic start_a(input int len);
        bus_a.start     = 1'b1;
        bus_a.batch_len = 9'(len);
        step();
        bus_a.start     = 1'b0;
    endtask

    // gap: 0 = back to back, 1 = random idles, 2 = toggled valid
    task automatic feed_a(input int len, input int gap);
        int i;
        int cyc;
        bit take;
        i   = 0;
        cyc = 0;
        while (i < len && cyc < 4 * len + 64) begin
            if ((gap == 1 && $urandom_range(0, 1) == 1) || (gap == 2 && cyc % 2 == 1)) begin
                bus_a.in_valid = 1'b0;
            end else begin
                bus_a.in_valid = 1'b1;
                bus_a.in_yhat  = fix_t'(ya[i]);
                bus_a.in_y     = fix_t'(ra[i]);
            end
            take = bus_a.in_valid && bus_a.in_ready;
            step();
            if (take) i++;
            cyc++;
        end
        bus_a.in_valid = 1'b0;
        chk("feed_timeout", longint'(i), longint'(len));
    endtask

    task automatic wait_valid_a(input string tag);
        int n;
        n = 0;
        while (!bus_a.loss_valid && n < 100) begin
            step();
            n++;
        end
        chk(tag, longint'(bus_a.loss_valid), 1);
    endtask

    task automatic ack_a(input string tag);
        bus_a.loss_ready = 1'b1;
        step();
        bus_a.loss_ready = 1'b0;
        chk({tag, "_lv_drop"}, longint'(bus_a.loss_valid), 0);
        chk({tag, "_idle"}, longint'(bus_a.busy), 0);
    endtask

    initial begin
        int base;
        int len;
        longint exp;

        reset            = 1'b1;
        bus_a.start      = 1'b0; bus_a.batch_len = '0; bus_a.in_valid = 1'b0;
        bus_a.in_yhat    = '0;   bus_a.in_y      = '0; bus_a.loss_ready = 1'b0;
        bus_b.start      = 1'b0; bus_b.batch_len = '0; bus_b.in_valid = 1'b0;
        bus_b.in_yhat    = '0;   bus_b.in_y      = '0; bus_b.loss_ready = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_in_ready", longint'(bus_a.in_ready), 0);
        chk("rst_loss_valid", longint'(bus_a.loss_valid), 0);
        chk("rst_loss", longint'(bus_a.loss), 0);
        chk("rst_busy", longint'(bus_a.busy), 0);
        reset = 1'b0;
        step();

        // Test 1: single chunk, yHat=j, y=3
        for (int j = 0; j < 10; j++) begin ya[j] = j; ra[j] = 3; end
        start_a(10);
        chk("t1_busy", longint'(bus_a.busy), 1);
        feed_a(10, 0);
        chk("t1_lv_early", longint'(bus_a.loss_valid), 0);
        step();
        chk("t1_lv_latency", longint'(bus_a.loss_valid), 1);
        chk("t1_loss", longint'(bus_a.loss), 27);
        ack_a("t1");

        // Test 2: two chunks (15 + 5)
        for (int j = 0; j < 20; j++) begin ya[j] = 5; ra[j] = 2; end
        base = n_compute_a;
        start_a(20);
        feed_a(20, 0);
        wait_valid_a("t2_timeout");
        chk("t2_loss", longint'(bus_a.loss), 60);
        chk("t2_compute_cycles", longint'(n_compute_a - base), 2);
        ack_a("t2");

        // Test 3: empty batch
        base = n_inready_a;
        start_a(0);
        chk("t3_lv", longint'(bus_a.loss_valid), 1);
        chk("t3_loss", longint'(bus_a.loss), 0);
        step();
        chk("t3_no_in_ready", longint'(n_inready_a - base), 0);
        ack_a("t3");

        // Test 4: toggled valid, held result, start ignored in DONE
        for (int j = 0; j < 4; j++) begin ya[j] = rand_fix(); ra[j] = rand_fix(); end
        exp = model(4, ACCW_A);
        start_a(4);
        feed_a(4, 2);
        wait_valid_a("t4_timeout");
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_lv", longint'(bus_a.loss_valid), 1);
            chk("t4_hold_loss", longint'($signed(bus_a.loss)), exp);
            if (k == 2) begin
                bus_a.start     = 1'b1;
                bus_a.batch_len = 9'd7;
            end
            step();
            bus_a.start = 1'b0;
        end
        chk("t4_after_start_loss", longint'($signed(bus_a.loss)), exp);
        ack_a("t4");

        // Test 5: async reset mid-FILL, then a clean batch
        for (int j = 0; j < 20; j++) begin ya[j] = rand_fix(); ra[j] = rand_fix(); end
        start_a(20);
        feed_a(7, 0);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_in_ready", longint'(bus_a.in_ready), 0);
        chk("t5_rst_busy", longint'(bus_a.busy), 0);
        chk("t5_rst_loss", longint'(bus_a.loss), 0);
        chk("t5_rst_lv", longint'(bus_a.loss_valid), 0);
        step();
        reset = 1'b0;
        step();
        for (int j = 0; j < 3; j++) begin ya[j] = rand_fix(); ra[j] = rand_fix(); end
        start_a(3);
        feed_a(3, 0);
        wait_valid_a("t5_timeout");
        chk("t5_loss", longint'($signed(bus_a.loss)), model(3, ACCW_A));
        ack_a("t5");

        // Random batches incl. chunk-boundary lengths and the largest batch
        for (int k = 0; k < 7; k++) begin
            len = (k == 0) ? 15 : (k == 1) ? 16 : (k == 2) ? 256 : (k == 3) ? 1
                : int'($urandom_range(2, 60));
            for (int j = 0; j < len; j++) begin ya[j] = rand_fix(); ra[j] = rand_fix(); end
            start_a(len);
            feed_a(len, 1);
            wait_valid_a("rnd_timeout");
            chk("rnd_loss", longint'($signed(bus_a.loss)), model(len, ACCW_A));
            ack_a("rnd");
        end

        // Test 6: small accumulator, extreme inputs
        ya[0] = (1 << 19) - 1; ra[0] = -(1 << 19);
        ya[1] = (1 << 19) - 1; ra[1] = -(1 << 19);
        bus_b.start     = 1'b1;
        bus_b.batch_len = 2'd2;
        step();
        bus_b.start = 1'b0;
        begin
            int i;
            int cyc;
            bit take;
            i = 0; cyc = 0;
            while (i < 2 && cyc < 20) begin
                bus_b.in_valid = 1'b1;
                bus_b.in_yhat  = fix_t'(ya[i]);
                bus_b.in_y     = fix_t'(ra[i]);
                take = bus_b.in_ready;
                step();
                if (take) i++;
                cyc++;
            end
            bus_b.in_valid = 1'b0;
            cyc = 0;
            while (!bus_b.loss_valid && cyc < 20) begin step(); cyc++; end
        end
        chk("t6_lv", longint'(bus_b.loss_valid), 1);
        chk("t6_loss", longint'($signed(bus_b.loss)), model(2, ACCW_B));
`ifdef L1_ACC_SAT_EN
        chk("t6_sat_flag", longint'(bus_b.sat_flag), 1);
`endif
        bus_b.loss_ready = 1'b1;
        step();
        bus_b.loss_ready = 1'b0;
        chk("t6_lv_drop", longint'(bus_b.loss_valid), 0);
`ifdef L1_ACC_SAT_EN
        bus_b.start     = 1'b1;
        bus_b.batch_len = 2'd1;
        step();
        bus_b.start = 1'b0;
        chk("t6_sat_clear", longint'(bus_b.sat_flag), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
